// File: rtl/net_router_output_ctrl_pkg.sv
// Shared constants for the ring router output controllers: port indices,
// default requester count, counter width and the select-width helper.
package net_router_output_ctrl_pkg;

   // Bit positions in the 3'b100/010/001 request encoding
   localparam int c_port_fwd  = 0;
   localparam int c_port_term = 1;
   localparam int c_port_bwd  = 2;

   localparam int c_num_reqs_dflt = 3;
   localparam int c_count_nbits   = 16;

   // Keep the select at least one bit wide so a single-requester build stays legal
   function automatic int sel_nbits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/net_router_output_ctrl_if.sv
// Request/grant/select and output handshake bundle between the input
// controllers, the crossbar and one output port controller.
interface net_router_output_ctrl_if
   import net_router_output_ctrl_pkg::*;
#(
   parameter int p_num_reqs = c_num_reqs_dflt
);
   localparam int c_sel_nbits = sel_nbits(p_num_reqs);

   logic [p_num_reqs-1:0]  reqs;
   logic [p_num_reqs-1:0]  grants;
   logic [c_sel_nbits-1:0] sel;
   logic                   out_val;
   logic                   out_rdy;

   modport master (output reqs, output out_rdy, input grants, input sel, input out_val);
   modport slave  (input reqs, input out_rdy, output grants, output sel, output out_val);
endinterface

// File: rtl/net_rr_arb_core.sv
// Combinational rotating-priority scan: picks the first request at or above
// the one-hot prio position, wrapping past the top bit.
module net_rr_arb_core
   import net_router_output_ctrl_pkg::*;
#(
   parameter int p_num_reqs = c_num_reqs_dflt,
   localparam int c_sel_nbits = sel_nbits(p_num_reqs)
)(
   input  logic [p_num_reqs-1:0]  reqs,
   input  logic [p_num_reqs-1:0]  prio,
   output logic [p_num_reqs-1:0]  win,
   output logic [c_sel_nbits-1:0] win_idx
);

   logic [c_sel_nbits-1:0] base;
   logic                   found;
   int                     idx;

   always_comb begin
      base = '0;
      for (int i = 0; i < p_num_reqs; i++)
         if (prio[i]) base = c_sel_nbits'(i);
      win     = '0;
      win_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < p_num_reqs; k++) begin
         idx = (int'(base) + k) % p_num_reqs;
         if (!found && reqs[idx]) begin
            found        = 1'b1;
            win[idx]     = 1'b1;
            win_idx      = c_sel_nbits'(idx);
         end
      end
   end

endmodule

// File: rtl/net_router_output_ctrl.sv
// Output port controller: round-robin grant, crossbar select, output
// handshake and a saturating delivered-message counter.
module net_router_output_ctrl
   import net_router_output_ctrl_pkg::*;
#(
   parameter int p_num_reqs    = c_num_reqs_dflt,
   parameter int p_count_nbits = c_count_nbits
)(
   input  logic                     clk,
   input  logic                     reset,
   net_router_output_ctrl_if.slave  bus,
   input  logic                     count_clear,
   output logic [p_count_nbits-1:0] count
);
   localparam int c_sel_nbits = sel_nbits(p_num_reqs);

   logic [p_num_reqs-1:0]  prio;
   logic [p_num_reqs-1:0]  prio_nxt;
   logic [p_num_reqs-1:0]  win;
   logic [c_sel_nbits-1:0] win_idx;
   logic                   xfer;

   net_rr_arb_core #(.p_num_reqs(p_num_reqs)) u_arb (
      .reqs    (bus.reqs),
      .prio    (prio),
      .win     (win),
      .win_idx (win_idx)
   );

   // Single-flit messages: valid is just "anyone wants this output"
   assign bus.out_val = |bus.reqs;
   assign xfer        = bus.out_val & bus.out_rdy;
   assign bus.grants  = xfer ? win : '0;
   assign bus.sel     = win_idx;

   // Winner drops to lowest priority after it transfers
   always_comb begin
      prio_nxt = '0;
      for (int i = 0; i < p_num_reqs; i++)
         prio_nxt[(i + 1) % p_num_reqs] = win[i];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prio  <= p_num_reqs'(1);
         count <= '0;
      end else begin
         if (xfer) prio <= prio_nxt;
         if (count_clear)
            count <= '0;
         else if (xfer && count != '1)
            count <= count + p_count_nbits'(1);
      end
   end

endmodule

// File: doc/net_router_output_ctrl.md
Name: net_router_output_ctrl

Overview:
- Per-output-port controller for the ring router; one instance per output (two ring directions plus terminal).
- Collects the one-hot requests that each input controller raises toward this output and grants exactly one per cycle with round-robin fairness.
- Drives the crossbar select, the output val/rdy handshake, and a saturating delivered-message counter for performance debug.

Parameters:
- p_num_reqs, 3, number of requesting input ports; bit i of reqs/grants belongs to input port i.
- p_count_nbits, 16, width of the delivered-message counter.
- c_sel_nbits, $clog2(p_num_reqs), derived crossbar select width; not set externally.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- reqs  input  p_num_reqs  bit i high when input i holds a valid message routed to this output.
- grants  output  p_num_reqs  one-hot or zero; bit i high means input i transfers this cycle.
- sel  output  c_sel_nbits  crossbar mux select, equal to the index of the current arbitration winner.
- out_val  output  1  valid toward downstream router or terminal.
- out_rdy  input  1  downstream ready.
- count_clear  input  1  synchronous clear of the delivered counter.
- count  output  p_count_nbits  number of completed output transfers, saturating.

Behaviour:
- State:
  - prio, p_num_reqs-bit one-hot priority pointer; reset value 'b0…01, so input 0 has highest priority.
  - count register; reset value 0.
- out_val = |reqs. Combinational; no added latency, since messages are single-flit.
- Winner: the first set bit of reqs, scanning upward from the prio position with wrap-around past bit p_num_reqs-1.
  - sel = index of the winner.
  - sel = 0 when reqs == 0.
- grants = one-hot winner when out_rdy && out_val, else 0. There is never more than one grant bit set.
- Transfer occurs when out_val && out_rdy.
  - On a transfer, next prio = winner rotated left by one with wrap, so the winner becomes lowest priority.
  - Without a transfer, prio holds. A blocked winner therefore keeps its claim, and no request is ever dropped.
- Count:
  - On a transfer, count increments by 1.
  - At all-ones it holds (saturates); it never wraps.
- count_clear:
  - Sets count to 0 next cycle.
  - Has priority over a simultaneous increment.
  - Does not affect prio.
- Reset:
  - Reset mid-operation forces prio and count to their reset values on the next edge, regardless of other inputs.
  - Outputs stay purely combinational functions of reqs, out_rdy and state; while reset is asserted, grants still follows the reset-valued prio.
- Combinational paths: out_rdy to grants, and reqs to grants/sel/out_val. Upstream reqs must not depend on grants, which keeps the path loop-free.
- Boundaries:
  - reqs == 0: out_val=0, grants=0, prio held.
  - out_rdy=1 with out_val=0: no transfer, no count change.
  - A single requester is granted regardless of prio.
  - prio must remain one-hot in every state.

Decomposition:
- Shared package/header holds:
  - port-index constants: 0 = forward ring direction, 1 = terminal, 2 = backward ring direction, matching the 3'b100/010/001 request encoding;
  - the default p_num_reqs;
  - the counter width.
- One natural sub-module: net_rr_arb_core.
  - Combinational: reqs + prio in, one-hot winner + index out.
  - Keeps the rotating-priority scan separate from the state and counter logic.

Test Plan:
- Reset, then reqs=3'b111, out_rdy=1 for 3 cycles -> grants 001, 010, 100; sel 0, 1, 2; count=3.
- reqs=3'b101, out_rdy=1 for 4 cycles after reset -> grants alternate 001, 100, 001, 100; input 1 is never granted.
- reqs=3'b110, out_rdy=0 for 5 cycles, then 1 -> out_val=1 throughout; grants=000 while stalled; sel=1 held; first grant 010; count=1.
- Preload count to 16'hFFFE via transfers (or force), apply 3 transfers -> count 16'hFFFF and holds; count_clear with a simultaneous transfer -> count=0.
- Mid-stream reset with prio pointing at input 2 and reqs=3'b111 -> next cycle grants=001, count=0.
- Random reqs/out_rdy for 10k cycles -> grants always one-hot or zero; every held request granted within p_num_reqs transfers; count equals the scoreboard transfer total.
